// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, field positions
// and interrupt cause codes.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  typedef struct packed {
    logic impl;
    logic ro;
  } csr_decode_t;

  function automatic int mcause_irq_bit(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Wrapping XLEN-bit counter with masked CSR write; a write beats the increment.
module csr_counter
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            we,
  input  logic [XLEN-1:0] wmask,
  input  logic [XLEN-1:0] wvalue,
  output logic [XLEN-1:0] count
);

  logic [XLEN-1:0] count_r;

  // Counter state: reset, masked write, or increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (we) begin
      count_r <= (wmask & wvalue) | (~wmask & count_r);
    end else if (inc) begin
      count_r <= count_r + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSR access, trap/mret state, interrupt selection,
// trap entry PC and the mcycle/minstret counters.
module csr_file_m
  import csr_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [63:0] HART_ID     = 64'd0,
  parameter logic [63:0] MTVEC_RST   = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_re,
  input  logic            csr_we,
  input  logic [11:0]     csr_num,
  input  logic [XLEN-1:0] csr_wmask,
  input  logic [XLEN-1:0] csr_wvalue,
  output logic [XLEN-1:0] csr_rvalue,
  output logic            csr_illegal,
  input  logic            ex,
  input  logic [XLEN-2:0] ecode,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] tval,
  input  logic            ex_ret,
  input  logic            instret,
  input  logic            irq_mtip,
  input  logic            irq_msip,
  input  logic            irq_meip,
  output logic            irq_take,
  input  logic            irq_ack,
  output logic [XLEN-1:0] ex_entry,
  output logic [XLEN-1:0] mepc_out
);

  localparam logic [1:0]      MXL      = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA_VAL = {MXL, {(XLEN-11){1'b0}}, 9'h100};
  localparam logic [XLEN-1:0] IRQ_FLAG = {{(XLEN-1){1'b0}}, 1'b1} << mcause_irq_bit(XLEN);

  logic            mstatus_mie_r, mstatus_mpie_r;
  logic            mie_meie_r, mie_msie_r, mie_mtie_r;
  logic [XLEN-1:0] mtvec_r, mepc_r, mcause_r, mtval_r, mscratch_r;
  logic [XLEN-1:0] mcycle_s, minstret_s;
  logic [XLEN-1:0] rdata_s, wdata_s, base_s, irq_cause_s;
  csr_decode_t     dec_s;
  logic            illegal_s, wr_s, trap_s, vec_s;
  logic [2:0]      pend_s;
  logic [3:0]      irq_code_s;

  // Read mux and address decode for every implemented CSR
  always_comb begin
    rdata_s = '0;
    dec_s   = '{impl: 1'b0, ro: 1'b0};
    case (csr_num)
      CSR_MSTATUS: begin
        rdata_s[MSTATUS_MIE]                   = mstatus_mie_r;
        rdata_s[MSTATUS_MPIE]                  = mstatus_mpie_r;
        rdata_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        dec_s.impl = 1'b1;
      end
      CSR_MISA:     begin rdata_s = MISA_VAL;   dec_s = '{impl: 1'b1, ro: 1'b1}; end
      CSR_MIE: begin
        rdata_s[11] = mie_meie_r;
        rdata_s[7]  = mie_mtie_r;
        rdata_s[3]  = mie_msie_r;
        dec_s.impl  = 1'b1;
      end
      CSR_MTVEC:    begin rdata_s = mtvec_r;    dec_s.impl = 1'b1; end
      CSR_MSCRATCH: begin rdata_s = mscratch_r; dec_s.impl = 1'b1; end
      CSR_MEPC:     begin rdata_s = mepc_r;     dec_s.impl = 1'b1; end
      CSR_MCAUSE:   begin rdata_s = mcause_r;   dec_s.impl = 1'b1; end
      CSR_MTVAL:    begin rdata_s = mtval_r;    dec_s.impl = 1'b1; end
      CSR_MIP: begin
        rdata_s[11] = irq_meip;
        rdata_s[7]  = irq_mtip;
        rdata_s[3]  = irq_msip;
        dec_s       = '{impl: 1'b1, ro: 1'b1};
      end
      CSR_MCYCLE:   begin rdata_s = mcycle_s;   dec_s.impl = 1'b1; end
      CSR_MINSTRET: begin rdata_s = minstret_s; dec_s.impl = 1'b1; end
      CSR_MHARTID:  begin rdata_s = HART_ID[XLEN-1:0]; dec_s = '{impl: 1'b1, ro: 1'b1}; end
      default:      begin rdata_s = '0; dec_s = '{impl: 1'b0, ro: 1'b0}; end
    endcase
  end

  assign illegal_s   = (csr_re | csr_we) & (~dec_s.impl | (csr_we & dec_s.ro));
  assign wr_s        = csr_we & ~illegal_s;
  assign wdata_s     = (csr_wmask & csr_wvalue) | (~csr_wmask & rdata_s);
  assign csr_rvalue  = csr_re ? rdata_s : '0;
  assign csr_illegal = illegal_s;
  assign trap_s      = ex | irq_ack;

  assign pend_s   = {irq_meip & mie_meie_r, irq_msip & mie_msie_r, irq_mtip & mie_mtie_r};
  assign irq_take = mstatus_mie_r & (|pend_s);

  // Fixed interrupt priority: external, then software, then timer
  always_comb begin
    if (pend_s[2]) begin
      irq_code_s = IRQ_MEI;
    end else if (pend_s[1]) begin
      irq_code_s = IRQ_MSI;
    end else if (pend_s[0]) begin
      irq_code_s = IRQ_MTI;
    end else begin
      irq_code_s = 4'd0;
    end
  end

  assign irq_cause_s = IRQ_FLAG | {{(XLEN-4){1'b0}}, irq_code_s};
  assign base_s      = {mtvec_r[XLEN-1:2], 2'b00};
  // A coincident exception takes the trap, so only a pure interrupt vectors
  assign vec_s       = mtvec_r[0] & irq_take & ~ex;
  assign ex_entry    = vec_s ? base_s + {{(XLEN-6){1'b0}}, irq_code_s, 2'b00} : base_s;
  assign mepc_out    = mepc_r;

  // Trap-owned state: trap beats mret, mret beats a CSR write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mepc_r         <= '0;
      mcause_r       <= '0;
      mtval_r        <= '0;
    end else if (trap_s) begin
      mepc_r         <= {epc[XLEN-1:2], 2'b00};
      mtval_r        <= ex ? tval : '0;
      mcause_r       <= ex ? {1'b0, ecode} : irq_cause_s;
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else begin
      if (ex_ret) begin
        mstatus_mie_r  <= mstatus_mpie_r;
        mstatus_mpie_r <= 1'b1;
      end else if (wr_s && csr_num == CSR_MSTATUS) begin
        mstatus_mie_r  <= wdata_s[MSTATUS_MIE];
        mstatus_mpie_r <= wdata_s[MSTATUS_MPIE];
      end
      if (wr_s && csr_num == CSR_MEPC)   mepc_r   <= {wdata_s[XLEN-1:2], 2'b00};
      if (wr_s && csr_num == CSR_MCAUSE) mcause_r <= wdata_s;
      if (wr_s && csr_num == CSR_MTVAL)  mtval_r  <= wdata_s;
    end
  end

  // CSRs untouched by traps: written only by CSR instructions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtvec_r    <= {MTVEC_RST[XLEN-1:2], 2'b00};
      mie_meie_r <= 1'b0;
      mie_msie_r <= 1'b0;
      mie_mtie_r <= 1'b0;
      mscratch_r <= '0;
    end else if (wr_s) begin
      case (csr_num)
        CSR_MTVEC: mtvec_r <= {wdata_s[XLEN-1:2], 1'b0, VECTORED_EN & wdata_s[0]};
        CSR_MIE: begin
          mie_meie_r <= wdata_s[11];
          mie_mtie_r <= wdata_s[7];
          mie_msie_r <= wdata_s[3];
        end
        CSR_MSCRATCH: mscratch_r <= wdata_s;
        default: mscratch_r <= mscratch_r;
      endcase
    end
  end

  csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (1'b1),
    .we     (wr_s && csr_num == CSR_MCYCLE),
    .wmask  (csr_wmask),
    .wvalue (csr_wvalue),
    .count  (mcycle_s)
  );

  csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (instret),
    .we     (wr_s && csr_num == CSR_MINSTRET),
    .wmask  (csr_wmask),
    .wvalue (csr_wvalue),
    .count  (minstret_s)
  );

endmodule

// File: tb/tb_csr_file_m.sv
// Scoreboard bench for csr_file_m: expectations are queued as stimulus is
// driven and compared against the DUT at the following falling edge.
module tb_csr_file_m;

  localparam int XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] IBIT = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst_n, csr_re, csr_we, ex, ex_ret, instret;
  logic [11:0]     csr_num;
  logic [63:0]     csr_wmask, csr_wvalue, epc, tval;
  logic [62:0]     ecode;
  logic            irq_mtip, irq_msip, irq_meip, irq_ack;
  logic [63:0]     csr_rvalue, ex_entry, mepc_out;
  logic            csr_illegal, irq_take;

  int checks = 0;
  int errors = 0;
  logic [63:0] cyc_model;

  string       tag_q[$];
  int          sel_q[$];
  logic [63:0] exp_q[$];

  csr_file_m #(
    .XLEN(XLEN), .VECTORED_EN(1'b1), .HART_ID(64'd3), .MTVEC_RST(64'h8000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .csr_illegal(csr_illegal), .ex(ex), .ecode(ecode), .epc(epc), .tval(tval),
    .ex_ret(ex_ret), .instret(instret), .irq_mtip(irq_mtip), .irq_msip(irq_msip),
    .irq_meip(irq_meip), .irq_take(irq_take), .irq_ack(irq_ack),
    .ex_entry(ex_entry), .mepc_out(mepc_out)
  );

  always #5 clk = ~clk;

  // Reference cycle count, independent of the DUT
  always @(posedge clk) begin
    if (!rst_n) cyc_model <= 64'd0;
    else        cyc_model <= cyc_model + 64'd1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [63:0] exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  // Compare all queued expectations at the falling edge, then advance one cycle
  task automatic drain();
    logic [63:0] obs;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      case (sel_q[0])
        0:       obs = csr_rvalue;
        1:       obs = {63'd0, csr_illegal};
        2:       obs = {63'd0, irq_take};
        3:       obs = ex_entry;
        default: obs = mepc_out;
      endcase
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
      void'(sel_q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    csr_re = 1'b1; csr_num = addr;
    push(tag, 0, exp);
    drain();
    csr_re = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [63:0] mask, input logic [63:0] val);
    csr_we = 1'b1; csr_num = addr; csr_wmask = mask; csr_wvalue = val;
    step();
    csr_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; csr_re = 1'b0; csr_we = 1'b0; csr_num = 12'h000;
    csr_wmask = 64'd0; csr_wvalue = 64'd0; ex = 1'b0; ecode = 63'd0;
    epc = 64'd0; tval = 64'd0; ex_ret = 1'b0; instret = 1'b0;
    irq_mtip = 1'b0; irq_msip = 1'b0; irq_meip = 1'b0; irq_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rd("rst_mtvec", 12'h305, 64'h8000_0000);
    rd("rst_mstatus", 12'h300, 64'h1800);
    rd("rst_mcycle", 12'hB00, cyc_model);
    rd("rst_mie", 12'h304, 64'd0);
    rd("hartid", 12'hF14, 64'd3);

    csr_we = 1'b1; csr_num = 12'h301; csr_wmask = ONES; csr_wvalue = 64'd0;
    push("misa_wr_illegal", 1, 64'd1);
    drain();
    csr_we = 1'b0;
    rd("misa_unchanged", 12'h301, 64'h8000_0000_0000_0100);
    csr_re = 1'b1; csr_num = 12'h7C0;
    push("unimpl_illegal", 1, 64'd1);
    push("unimpl_rdata", 0, 64'd0);
    drain();
    csr_re = 1'b0;

    // Vectored timer interrupt
    wr(12'h305, ONES, 64'h8000_0101);
    wr(12'h304, ONES, 64'h80);
    wr(12'h300, 64'h8, 64'h8);
    irq_mtip = 1'b1;
    push("mti_take", 2, 64'd1);
    push("mti_entry", 3, 64'h8000_011C);
    drain();
    irq_ack = 1'b1; epc = 64'h8000_0200;
    step();
    irq_ack = 1'b0;
    rd("irq_mcause", 12'h342, IBIT | 64'd7);
    rd("irq_mstatus", 12'h300, 64'h1880);
    rd("irq_mepc", 12'h341, 64'h8000_0200);
    rd("irq_mtval", 12'h343, 64'd0);

    // Exception, interrupt ack and mepc write all in one cycle
    wr(12'h300, 64'h8, 64'h8);
    ex = 1'b1; ecode = 63'd2; epc = 64'h8000_0046; tval = 64'hDEAD; irq_ack = 1'b1;
    csr_we = 1'b1; csr_num = 12'h341; csr_wmask = ONES; csr_wvalue = 64'h1234;
    push("ex_entry_base", 3, 64'h8000_0100);
    drain();
    ex = 1'b0; irq_ack = 1'b0; csr_we = 1'b0;
    rd("ex_mepc", 12'h341, 64'h8000_0044);
    rd("ex_mcause", 12'h342, 64'd2);
    rd("ex_mtval", 12'h343, 64'hDEAD);
    rd("ex_mstatus", 12'h300, 64'h1880);
    rd("mip_pending", 12'h344, 64'h80);

    ex_ret = 1'b1;
    step();
    ex_ret = 1'b0;
    push("mret_mepc_out", 4, 64'h8000_0044);
    push("mret_take", 2, 64'd1);
    rd("mret_mstatus", 12'h300, 64'h1888);

    // Priority MEI > MSI > MTI
    irq_msip = 1'b1; irq_meip = 1'b1;
    wr(12'h304, ONES, 64'h888);
    push("mei_entry", 3, 64'h8000_012C);
    drain();
    irq_meip = 1'b0;
    push("msi_entry", 3, 64'h8000_010C);
    drain();
    irq_ack = 1'b1; epc = 64'h8000_0300;
    step();
    irq_ack = 1'b0; irq_msip = 1'b0; irq_mtip = 1'b0;
    rd("msi_mcause", 12'h342, IBIT | 64'd3);

    // Trap beats mret; a write to an untouched CSR still lands
    ex = 1'b1; ecode = 63'd5; epc = 64'h10; tval = 64'd0; ex_ret = 1'b1;
    csr_we = 1'b1; csr_num = 12'h340; csr_wmask = ONES; csr_wvalue = 64'h55;
    step();
    ex = 1'b0; ex_ret = 1'b0; csr_we = 1'b0;
    rd("trap_vs_mret", 12'h300, 64'h1800);
    rd("trap_mscratch", 12'h340, 64'h55);
    rd("trap5_mcause", 12'h342, 64'd5);

    wr(12'h340, 64'hFF00, 64'hABCD);
    rd("masked_wr", 12'h340, 64'hAB55);
    wr(12'h341, ONES, 64'h1237);
    rd("mepc_align", 12'h341, 64'h1234);

    // Counter write beats increment, then wraps
    instret = 1'b1;
    wr(12'hB02, ONES, ONES);
    rd("minstret_ones", 12'hB02, ONES);
    instret = 1'b0;
    rd("minstret_wrap", 12'hB02, 64'd0);
    wr(12'hB00, ONES, 64'h100);
    rd("mcycle_wr", 12'hB00, 64'h100);

    // Reset during a trap
    ex = 1'b1; epc = 64'h999; tval = 64'd1; rst_n = 1'b0;
    step();
    ex = 1'b0; rst_n = 1'b1;
    rd("rst2_mepc", 12'h341, 64'd0);
    rd("rst2_mcause", 12'h342, 64'd0);
    rd("rst2_mtvec", 12'h305, 64'h8000_0000);
    rd("rst2_mstatus", 12'h300, 64'h1800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
